// File: rtl/bcd_multidigit_counter.sv
// N-digit BCD up/down counter: synchronous load with digit clamping, count
// enable, combinational terminal count. Define BCD_COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module bcd_multidigit_counter #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  logic [4*DIGITS-1:0] q_q, q_d;
  logic [4*DIGITS-1:0] load_clamped;
  logic [4*DIGITS-1:0] q_inc, q_dec;
  logic                wrap_q, wrap_d;
  logic                load_err_q, load_err_d;
  logic                any_invalid;
  logic                all_nine, all_zero, at_limit;
  logic                carry, borrow;
  logic [3:0]          ld_digit, cur_digit;

  always_comb begin
    load_clamped = '0;
    any_invalid  = 1'b0;
    ld_digit     = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      ld_digit = load_val[4*k +: 4];
      if (ld_digit > 4'd9) begin
        load_clamped[4*k +: 4] = 4'd9;
        any_invalid            = 1'b1;
      end else begin
        load_clamped[4*k +: 4] = ld_digit;
      end
    end
  end

  // Carry/borrow ripple through all decades in a single cycle.
  always_comb begin
    q_inc     = '0;
    q_dec     = '0;
    carry     = 1'b1;
    borrow    = 1'b1;
    all_nine  = 1'b1;
    all_zero  = 1'b1;
    cur_digit = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      cur_digit = q_q[4*k +: 4];
      if (carry) begin
        if (cur_digit == 4'd9) begin
          q_inc[4*k +: 4] = 4'd0;
        end else begin
          q_inc[4*k +: 4] = cur_digit + 4'd1;
          carry           = 1'b0;
        end
      end else begin
        q_inc[4*k +: 4] = cur_digit;
      end
      if (borrow) begin
        if (cur_digit == 4'd0) begin
          q_dec[4*k +: 4] = 4'd9;
        end else begin
          q_dec[4*k +: 4] = cur_digit - 4'd1;
          borrow          = 1'b0;
        end
      end else begin
        q_dec[4*k +: 4] = cur_digit;
      end
      all_nine = all_nine & (cur_digit == 4'd9);
      all_zero = all_zero & (cur_digit == 4'd0);
    end
  end

  assign at_limit = up ? all_nine : all_zero;
  assign tc       = en & at_limit;

  always_comb begin
    q_d        = q_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      q_d        = load_clamped;
      load_err_d = any_invalid;
    end else if (en) begin
`ifdef BCD_COUNTER_SATURATE_EN
      if (!at_limit) begin
        q_d = up ? q_inc : q_dec;
      end
`else
      q_d    = up ? q_inc : q_dec;
      wrap_d = at_limit;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
